ula_sequencial: RTL and testbench
=================================

# ula_sequencial

Parametrised, registered ALU for the MIPS datapath. It keeps the single-cycle operation set of the current combinational ALU and adds iterative multiply (shift-add) and divide (restoring), with a start/done handshake and HI/LO-style double results. Operands and opcode are captured on `Inicio`, so the control unit can stall on `Ocupado` during long operations.

## Interface
- `WIDTH`, 32: operand and result width (≥4, power of two).
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `Inicio` input 1: start strobe; captures `Dado1`, `Dado2`, `S`, `branch` when idle.
- `Dado1`, `Dado2` input WIDTH: unsigned operands.
- `S` input 4: opcode.
- `branch` input 1: branch-instruction qualifier for the compare opcodes.
- `Resultado` output WIDTH: LO result (product low word, quotient, or single-cycle result).
- `ResultadoAlto` output WIDTH: HI result (product high word, remainder); 0 for other ops.
- `zero`, `branchAtivo`, `Negativo`, `ErroDiv` output 1 each: flags.
- `Ocupado` output 1: multi-cycle operation in progress.
- `Pronto` output 1: one-cycle pulse; results valid.

## Operation
- Opcodes:
  - 0000 add; 0001 sub; 0100 and; 0101 or; 0110 not `Dado1`.
  - 0111 sub, `zero`=(difference==0).
  - 1000 `zero`=(`Dado1`>`Dado2`), `Resultado`=0.
  - 1001 `zero`=(`Dado1`<=`Dado2`), `Resultado`=0.
  - 1010 `Resultado`=0 if `Dado1`<`Dado2`, else 1.
  - 1011 `Dado2`+1.
  - 1100 sll; 1101 srl; 1110 sra. Shift amount is `Dado2[log2(WIDTH)-1:0]`; `Dado1` is shifted.
  - 1111 `Resultado`=0.
  - 0010 multiply, multi-cycle; 1011 is not reused.
  - 0011 divide, multi-cycle.
- Arithmetic is modulo 2^WIDTH with no overflow flag. All compares are unsigned.
- `branchAtivo` = captured `branch` & `zero` for opcodes 0111/1000/1001; 0 otherwise.
- `Negativo` = `Resultado[WIDTH-1]`, updated together with `Resultado`.
- Multiply: {`ResultadoAlto`,`Resultado`} = full 2·WIDTH-bit unsigned product, shift-add, one bit per cycle.
- Divide: `Resultado`=quotient, `ResultadoAlto`=remainder, restoring, one bit per cycle.
- Divide by zero: `Resultado`=all ones, `ResultadoAlto`=`Dado1`, `ErroDiv`=1. It still takes the full WIDTH cycles.
- `ErroDiv` is 0 for every other completion.
- Flags and results for non-multi-cycle ops: `ResultadoAlto`=0, `ErroDiv`=0.
- FSM states:
  - OCIOSO: `Inicio` with S∈{0010,0011} → MULT/DIV, counter←WIDTH, operands latched. `Inicio` with any other S → registered result, stays OCIOSO.
  - MULT/DIV: one iteration per cycle, counter decrements; counter reaching 0 → OCIOSO with result written.
- `Inicio` while `Ocupado`=1 is ignored. The operation in flight and its operands are unaffected.
- Outputs (`Resultado`, `ResultadoAlto`, flags) hold their last value until the next completion. They do not change during MULT/DIV.

## Timing
- Reset (asynchronous assert, any state): state OCIOSO, counter 0, all outputs 0.
  - An operation in flight is aborted and no `Pronto` is produced.
  - Reset deassertion is synchronous to `clock` by the surrounding logic.
- Single-cycle ops: `Inicio` sampled at edge E. Results, flags and `Pronto`=1 are visible after E. `Pronto` drops after E+1 unless a new `Inicio` is sampled at E+1.
- Back-to-back single-cycle ops: `Inicio` may be held high, giving one result and one `Pronto` per cycle.
- Multi-cycle ops: `Inicio` at edge E.
  - `Ocupado`=1 after E.
  - Iterations run at edges E+1..E+WIDTH.
  - After E+WIDTH: `Ocupado`=0, `Pronto`=1, results valid. Latency is WIDTH+1 edges (33 for WIDTH=32).
- New `Inicio` sampled at the same edge that completes a multi-cycle op (E+WIDTH) is ignored. The earliest accepted restart is E+WIDTH+1.
- `Pronto` and `Ocupado` are never high together.

## Test plan
- Reset mid-divide: start 0011 (100,7); assert `reset_n`=0 at cycle 10 → all outputs 0 immediately, no `Pronto`; next `Inicio` works normally.
- Single-cycle sweep, WIDTH=32, one op per cycle (`Inicio` held high):
  - 0000 (5,3) → 8.
  - 0001 (3,5) → 0xFFFFFFFE, `Negativo`=1.
  - 0111 (9,9) with `branch`=1 → `zero`=1, `branchAtivo`=1.
  - 1010 (2,7) → 0.
  - 1110 (0x80000000,4) → 0xF8000000.
  - `Pronto` high every cycle.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF → `ResultadoAlto`=0xFFFFFFFE, `Resultado`=0x00000001. `Pronto` exactly 33 edges after start; `Ocupado` high for 32 cycles.
- Divide 100/7 → `Resultado`=14, `ResultadoAlto`=2, `ErroDiv`=0.
- Divide 123/0 → `Resultado`=0xFFFFFFFF, `ResultadoAlto`=123, `ErroDiv`=1, same latency.
- `Inicio` with opcode 0000 pulsed during multiply busy → ignored; multiply result unchanged, single `Pronto`.
- Repeat the multiply and divide cases with WIDTH=8 (e.g. 200×200 → HI=0x9C, LO=0x40) → latency 9 edges.

Source files
------------

// File: rtl/ula_sequencial_if.sv
// ula_sequencial_if: operand/opcode bus and result/flag bus of the sequential ALU.
interface ula_sequencial_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Inicio;
    logic [WIDTH-1:0] Dado1;
    logic [WIDTH-1:0] Dado2;
    logic [3:0]       S;
    logic             branch;
    logic [WIDTH-1:0] Resultado;
    logic [WIDTH-1:0] ResultadoAlto;
    logic             zero;
    logic             branchAtivo;
    logic             Negativo;
    logic             ErroDiv;
    logic             Ocupado;
    logic             Pronto;

    // Control unit side
    modport master (
        output Inicio, Dado1, Dado2, S, branch,
        input  Resultado, ResultadoAlto, zero, branchAtivo, Negativo, ErroDiv, Ocupado, Pronto
    );

    // ALU side
    modport slave (
        input  Inicio, Dado1, Dado2, S, branch,
        output Resultado, ResultadoAlto, zero, branchAtivo, Negativo, ErroDiv, Ocupado, Pronto
    );
endinterface

// File: rtl/ula_sequencial.sv
// ula_sequencial: registered MIPS ALU with single-cycle ops plus iterative
// shift-add multiply and restoring divide (one bit per cycle, HI/LO results).
module ula_sequencial #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clock,
    input logic             reset_n,
    ula_sequencial_if.slave bus
);
    localparam int unsigned LOG2 = $clog2(WIDTH);
    localparam int unsigned CW   = LOG2 + 1;

    typedef enum logic [1:0] {StOcioso, StMult, StDiv} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_opb;     // multiplicand or divisor
    logic [WIDTH-1:0] r_hi_acc;  // partial product high word / partial remainder
    logic [WIDTH-1:0] r_lo_acc;  // multiplier bits / dividend bits becoming quotient
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_res_hi;
    logic             r_zero;
    logic             r_branch_ativo;
    logic             r_negativo;
    logic             r_erro_div;
    logic             r_pronto;

    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_diff;
    logic             w_zero;
    logic             w_cmp_op;
    logic [LOG2-1:0]  w_sh;
    logic [WIDTH:0]   w_msum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_dshift;
    logic [WIDTH:0]   w_dsub;
    logic             w_dge;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    assign w_sh   = bus.Dado2[LOG2-1:0];
    assign w_diff = bus.Dado1 - bus.Dado2;

    // Single-cycle result and zero flag from the live bus, sampled on Inicio.
    // zero is only meaningful for the compare/branch opcodes and is 0 elsewhere.
    always_comb begin
        w_res    = '0;
        w_zero   = 1'b0;
        w_cmp_op = 1'b0;
        case (bus.S)
            4'b0000: w_res = bus.Dado1 + bus.Dado2;
            4'b0001: w_res = w_diff;
            4'b0100: w_res = bus.Dado1 & bus.Dado2;
            4'b0101: w_res = bus.Dado1 | bus.Dado2;
            4'b0110: w_res = ~bus.Dado1;
            4'b0111: begin
                w_res    = w_diff;
                w_zero   = (w_diff == '0);
                w_cmp_op = 1'b1;
            end
            4'b1000: begin
                w_zero   = (bus.Dado1 > bus.Dado2);
                w_cmp_op = 1'b1;
            end
            4'b1001: begin
                w_zero   = (bus.Dado1 <= bus.Dado2);
                w_cmp_op = 1'b1;
            end
            4'b1010: w_res = {{(WIDTH-1){1'b0}}, ~(bus.Dado1 < bus.Dado2)};
            4'b1011: w_res = bus.Dado2 + WIDTH'(1);
            4'b1100: w_res = bus.Dado1 << w_sh;
            4'b1101: w_res = bus.Dado1 >> w_sh;
            4'b1110: w_res = $unsigned($signed(bus.Dado1) >>> w_sh);
            default: w_res = '0;
        endcase
    end

    // One shift-add step: conditionally add multiplicand to the high word, shift pair right.
    always_comb begin
        w_msum   = {1'b0, r_hi_acc} + (r_lo_acc[0] ? {1'b0, r_opb} : '0);
        w_mul_hi = w_msum[WIDTH:1];
        w_mul_lo = {w_msum[0], r_lo_acc[WIDTH-1:1]};
    end

    // One restoring-divide step. A zero divisor always "fits", which naturally
    // yields an all-ones quotient and leaves the dividend as the remainder.
    always_comb begin
        w_dshift = {r_hi_acc, r_lo_acc[WIDTH-1]};
        w_dge    = (w_dshift >= {1'b0, r_opb});
        w_dsub   = w_dshift - {1'b0, r_opb};
        w_div_hi = w_dge ? w_dsub[WIDTH-1:0] : w_dshift[WIDTH-1:0];
        w_div_lo = {r_lo_acc[WIDTH-2:0], w_dge};
    end

    // FSM, iteration datapath and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= StOcioso;
            r_count        <= '0;
            r_opb          <= '0;
            r_hi_acc       <= '0;
            r_lo_acc       <= '0;
            r_res          <= '0;
            r_res_hi       <= '0;
            r_zero         <= 1'b0;
            r_branch_ativo <= 1'b0;
            r_negativo     <= 1'b0;
            r_erro_div     <= 1'b0;
            r_pronto       <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_state)
                StOcioso: begin
                    if (bus.Inicio) begin
                        if (bus.S == 4'b0010 || bus.S == 4'b0011) begin
                            r_state  <= (bus.S == 4'b0010) ? StMult : StDiv;
                            r_count  <= CW'(WIDTH);
                            r_opb    <= bus.Dado2;
                            r_hi_acc <= '0;
                            r_lo_acc <= bus.Dado1;
                        end else begin
                            r_res          <= w_res;
                            r_res_hi       <= '0;
                            r_zero         <= w_zero;
                            r_branch_ativo <= bus.branch & w_zero & w_cmp_op;
                            r_negativo     <= w_res[WIDTH-1];
                            r_erro_div     <= 1'b0;
                            r_pronto       <= 1'b1;
                        end
                    end
                end
                StMult: begin
                    r_hi_acc <= w_mul_hi;
                    r_lo_acc <= w_mul_lo;
                    r_count  <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state        <= StOcioso;
                        r_res          <= w_mul_lo;
                        r_res_hi       <= w_mul_hi;
                        r_zero         <= 1'b0;
                        r_branch_ativo <= 1'b0;
                        r_negativo     <= w_mul_lo[WIDTH-1];
                        r_erro_div     <= 1'b0;
                        r_pronto       <= 1'b1;
                    end
                end
                StDiv: begin
                    r_hi_acc <= w_div_hi;
                    r_lo_acc <= w_div_lo;
                    r_count  <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state        <= StOcioso;
                        r_res          <= w_div_lo;
                        r_res_hi       <= w_div_hi;
                        r_zero         <= 1'b0;
                        r_branch_ativo <= 1'b0;
                        r_negativo     <= w_div_lo[WIDTH-1];
                        r_erro_div     <= (r_opb == '0);
                        r_pronto       <= 1'b1;
                    end
                end
                default: r_state <= StOcioso;
            endcase
        end
    end

    assign bus.Resultado     = r_res;
    assign bus.ResultadoAlto = r_res_hi;
    assign bus.zero          = r_zero;
    assign bus.branchAtivo   = r_branch_ativo;
    assign bus.Negativo      = r_negativo;
    assign bus.ErroDiv       = r_erro_div;
    assign bus.Ocupado       = (r_state != StOcioso);
    assign bus.Pronto        = r_pronto;
endmodule

// File: tb/tb_ula_sequencial.sv
// tb_ula_sequencial: directed bench for 32-bit and 8-bit instances with an expected-result queue.
module tb_ula_sequencial;
    logic clock;
    logic reset_n;

    ula_sequencial_if #(.WIDTH(32)) b32 ();
    ula_sequencial_if #(.WIDTH(8))  b8 ();

    ula_sequencial #(.WIDTH(32)) u32 (.clock(clock), .reset_n(reset_n), .bus(b32));
    ula_sequencial #(.WIDTH(8))  u8  (.clock(clock), .reset_n(reset_n), .bus(b8));

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  fl;  // {zero, branchAtivo, Negativo, ErroDiv}
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] g_res(bit sel);
        return sel ? {24'b0, b8.Resultado} : b32.Resultado;
    endfunction
    function automatic logic [31:0] g_hi(bit sel);
        return sel ? {24'b0, b8.ResultadoAlto} : b32.ResultadoAlto;
    endfunction
    function automatic logic [3:0] g_fl(bit sel);
        return sel ? {b8.zero, b8.branchAtivo, b8.Negativo, b8.ErroDiv}
                   : {b32.zero, b32.branchAtivo, b32.Negativo, b32.ErroDiv};
    endfunction
    function automatic logic g_pronto(bit sel);
        return sel ? b8.Pronto : b32.Pronto;
    endfunction
    function automatic logic g_busy(bit sel);
        return sel ? b8.Ocupado : b32.Ocupado;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit sel, logic ini, logic [3:0] s, logic [31:0] a, logic [31:0] b,
                         logic br);
        if (sel) begin
            b8.Inicio = ini; b8.S = s; b8.Dado1 = a[7:0]; b8.Dado2 = b[7:0]; b8.branch = br;
        end else begin
            b32.Inicio = ini; b32.S = s; b32.Dado1 = a; b32.Dado2 = b; b32.branch = br;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_check(bit sel, string tag);
        exp_t e;
        n_assert++;
        assert (q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s: observed unexpected Pronto expected empty scoreboard", tag);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, " lo"}, g_res(sel), e.lo);
            chk({tag, " hi"}, g_hi(sel), e.hi);
            chk({tag, " flags"}, g_fl(sel), e.fl);
        end
    endtask

    // One single-cycle op with Inicio left high for the next step.
    task automatic sc(string tag, logic [3:0] s, logic [31:0] a, logic [31:0] b, logic br,
                      logic [31:0] lo, logic [3:0] fl);
        exp_t e;
        e.lo = lo; e.hi = 32'h0; e.fl = fl;
        q.push_back(e);
        drive(0, 1'b1, s, a, b, br);
        tick();
        chk({tag, " pronto"}, g_pronto(0), 1);
        pop_check(0, tag);
    endtask

    task automatic run_mc(bit sel, string tag, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                          logic [31:0] lo, logic [31:0] hi, logic [3:0] fl, bit pulse);
        exp_t        e;
        int          edges;
        int          busy;
        int          held;
        int          extra;
        int          wdt;
        logic [31:0] s_lo;
        logic [31:0] s_hi;
        wdt  = sel ? 8 : 32;
        s_lo = g_res(sel);
        s_hi = g_hi(sel);
        e.lo = lo; e.hi = hi; e.fl = fl;
        q.push_back(e);
        drive(sel, 1'b1, op, a, b, 1'b0);
        tick();
        edges = 1; busy = 0; held = 0;
        drive(sel, 1'b0, 4'b0000, 32'h5A5A5A5A, 32'h0F0F0F0F, 1'b0);
        chk({tag, " ocupado after start"}, g_busy(sel), 1);
        while (!g_pronto(sel) && edges < 100) begin
            if (g_busy(sel)) busy++;
            if (g_res(sel) !== s_lo || g_hi(sel) !== s_hi) held++;
            if (pulse && edges == 5) drive(sel, 1'b1, 4'b0000, 32'h11, 32'h22, 1'b0);
            else drive(sel, 1'b0, 4'b0000, 32'h11, 32'h22, 1'b0);
            tick();
            edges++;
        end
        chk({tag, " latency"}, edges, wdt + 1);
        chk({tag, " busy cycles"}, busy, wdt);
        chk({tag, " outputs held"}, held, 0);
        chk({tag, " ocupado at pronto"}, g_busy(sel), 0);
        pop_check(sel, tag);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (g_pronto(sel)) extra++;
        end
        chk({tag, " extra pronto"}, extra, 0);
    endtask

    initial begin
        int extra;
        drive(0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #2;
        chk("reset lo32", g_res(0), 0);
        chk("reset hi32", g_hi(0), 0);
        chk("reset flags32", {g_fl(0), g_busy(0), g_pronto(0)}, 0);
        chk("reset all8", {g_res(1), g_hi(1), g_fl(1), g_busy(1), g_pronto(1)}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Single-cycle sweep with Inicio held high
        sc("incr",   4'b1011, 32'h0,        32'd41, 1'b0, 32'd42,       4'b0000);
        sc("gt br",  4'b1000, 32'd9,        32'd3,  1'b1, 32'h0,        4'b1100);
        sc("le br",  4'b1001, 32'd9,        32'd3,  1'b1, 32'h0,        4'b0000);
        sc("sll",    4'b1100, 32'd1,        32'd35, 1'b0, 32'd8,        4'b0000);
        sc("not",    4'b0110, 32'h0F0F0F0F, 32'h0,  1'b0, 32'hF0F0F0F0, 4'b0010);
        sc("zero op",4'b1111, 32'd5,        32'd5,  1'b0, 32'h0,        4'b0000);
        sc("add",    4'b0000, 32'd5,        32'd3,  1'b0, 32'd8,        4'b0000);
        sc("sub",    4'b0001, 32'd3,        32'd5,  1'b0, 32'hFFFFFFFE, 4'b0010);
        sc("beq",    4'b0111, 32'd9,        32'd9,  1'b1, 32'h0,        4'b1100);
        sc("slt",    4'b1010, 32'd2,        32'd7,  1'b0, 32'h0,        4'b0000);
        sc("sra",    4'b1110, 32'h80000000, 32'd4,  1'b0, 32'hF8000000, 4'b0010);
        drive(0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        tick();
        chk("pronto drops", g_pronto(0), 0);

        // Reset in the middle of a divide
        drive(0, 1'b1, 4'b0011, 32'd100, 32'd7, 1'b0);
        tick();
        drive(0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        repeat (9) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("midreset lo", g_res(0), 0);
        chk("midreset hi", g_hi(0), 0);
        chk("midreset flags", {g_fl(0), g_busy(0), g_pronto(0)}, 0);
        tick();
        reset_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (g_pronto(0) || g_busy(0)) extra++;
        end
        chk("aborted divide silent", extra, 0);

        // Multi-cycle, WIDTH=32
        run_mc(0, "mul32", 4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 4'b0000, 1);
        run_mc(0, "div32", 4'b0011, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, 0);
        run_mc(0, "div0 32", 4'b0011, 32'd123, 32'd0, 32'hFFFFFFFF, 32'd123, 4'b0011, 0);

        // Multi-cycle, WIDTH=8
        run_mc(1, "mul8", 4'b0010, 32'd200, 32'd200, 32'h40, 32'h9C, 4'b0000, 1);
        run_mc(1, "div8", 4'b0011, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, 0);
        run_mc(1, "div0 8", 4'b0011, 32'd123, 32'd0, 32'hFF, 32'd123, 4'b0011, 0);

        chk("scoreboard drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
